// File: rtl/f32_mult_arb.sv
// Round-robin arbiter/sequencer sharing one f32_mult between NREQ requesters.
// Optional build macro MULT_TIMEOUT_EN adds a WAIT-state timeout returning qNaN with resp_err.
module f32_mult_arb #(
  parameter int NREQ           = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [32*NREQ-1:0]   req_a,
  input  logic [32*NREQ-1:0]   req_b,
  output logic [NREQ-1:0]      resp_valid,
  input  logic [NREQ-1:0]      resp_ready,
  output logic [31:0]          resp_p,
  output logic                 resp_err,
  output logic                 busy,
  output logic                 mul_start,
  output logic [31:0]          mul_a,
  output logic [31:0]          mul_b,
  input  logic                 mul_done,
  input  logic [31:0]          mul_p
);

  localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [GW-1:0] LAST_RST = GW'(NREQ - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  state_e            state_q;
  logic [GW-1:0]     gnt_q;
  logic [GW-1:0]     last_q;
  logic [31:0]       mul_a_q;
  logic [31:0]       mul_b_q;
  logic              mul_start_q;
  logic [NREQ-1:0]   resp_valid_q;
  logic [31:0]       resp_p_q;
  logic              busy_q;

  logic              gnt_found_s;
  logic [GW-1:0]     gnt_idx_s;
  logic [GW-1:0]     cand_s;
  int                idx_s;
  logic [NREQ-1:0]   gnt_oh_s;

`ifdef MULT_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0]     tmo_cnt_q;
  logic              resp_err_q;
`endif

  // Round-robin search starting just above the last served requester.
  always_comb begin
    gnt_found_s = 1'b0;
    gnt_idx_s   = '0;
    idx_s       = 0;
    cand_s      = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx_s = int'(last_q) + k;
      if (idx_s >= NREQ) begin
        idx_s = idx_s - NREQ;
      end else begin
        idx_s = idx_s;
      end
      cand_s = idx_s[GW-1:0];
      if (!gnt_found_s && req_valid[cand_s]) begin
        gnt_found_s = 1'b1;
        gnt_idx_s   = cand_s;
      end else begin
        gnt_found_s = gnt_found_s;
      end
    end
  end

  // Accept strobe is combinational so operands are taken in the grant cycle.
  always_comb begin
    req_ready = '0;
    if (rst_n && (state_q == IDLE) && gnt_found_s) begin
      req_ready[gnt_idx_s] = 1'b1;
    end else begin
      req_ready = '0;
    end
  end

  // One-hot form of the latched grant, used to steer the response.
  always_comb begin
    gnt_oh_s        = '0;
    gnt_oh_s[gnt_q] = 1'b1;
  end

  // Sequencer: IDLE -> ISSUE -> WAIT -> RESP, with all outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      gnt_q        <= '0;
      last_q       <= LAST_RST;
      mul_a_q      <= 32'h0000_0000;
      mul_b_q      <= 32'h0000_0000;
      mul_start_q  <= 1'b0;
      resp_valid_q <= '0;
      resp_p_q     <= 32'h0000_0000;
      busy_q       <= 1'b0;
`ifdef MULT_TIMEOUT_EN
      tmo_cnt_q    <= '0;
      resp_err_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (gnt_found_s) begin
            state_q     <= ISSUE;
            gnt_q       <= gnt_idx_s;
            mul_a_q     <= req_a[{gnt_idx_s, 5'd0} +: 32];
            mul_b_q     <= req_b[{gnt_idx_s, 5'd0} +: 32];
            mul_start_q <= 1'b1;
            busy_q      <= 1'b1;
          end else begin
            state_q <= IDLE;
          end
        end
        ISSUE: begin
          // mul_done here may be left over from the previous operation.
          state_q     <= WAIT;
          mul_start_q <= 1'b0;
`ifdef MULT_TIMEOUT_EN
          tmo_cnt_q   <= '0;
`endif
        end
        WAIT: begin
          if (mul_done) begin
            state_q      <= RESP;
            resp_p_q     <= mul_p;
            resp_valid_q <= gnt_oh_s;
`ifdef MULT_TIMEOUT_EN
            resp_err_q   <= 1'b0;
          end else if (tmo_cnt_q == TMO_LAST) begin
            state_q      <= RESP;
            resp_p_q     <= 32'h7FC0_0000;
            resp_valid_q <= gnt_oh_s;
            resp_err_q   <= 1'b1;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
          end
`else
          end else begin
            state_q <= WAIT;
          end
`endif
        end
        RESP: begin
          if (resp_ready[gnt_q]) begin
            state_q      <= IDLE;
            resp_valid_q <= '0;
            last_q       <= gnt_q;
            busy_q       <= 1'b0;
          end else begin
            state_q <= RESP;
          end
        end
        default: begin
          state_q      <= IDLE;
          mul_start_q  <= 1'b0;
          resp_valid_q <= '0;
          busy_q       <= 1'b0;
        end
      endcase
    end
  end

  assign mul_start  = mul_start_q;
  assign mul_a      = mul_a_q;
  assign mul_b      = mul_b_q;
  assign resp_valid = resp_valid_q;
  assign resp_p     = resp_p_q;
  assign busy       = busy_q;
`ifdef MULT_TIMEOUT_EN
  assign resp_err   = resp_err_q;
`else
  assign resp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_f32_mult_arb.sv
// Randomized self-checking bench for f32_mult_arb; the bench also plays the f32_mult.
module tb_f32_mult_arb;

  localparam int NREQ = 4;
  localparam int TMO  = 8;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_ready;
  logic [32*NREQ-1:0]  req_a;
  logic [32*NREQ-1:0]  req_b;
  logic [NREQ-1:0]     resp_valid;
  logic [NREQ-1:0]     resp_ready;
  logic [31:0]         resp_p;
  logic                resp_err;
  logic                busy;
  logic                mul_start;
  logic [31:0]         mul_a;
  logic [31:0]         mul_b;
  logic                mul_done;
  logic [31:0]         mul_p;

  int n_checks = 0;
  int n_errors = 0;
  int last_g;
  logic [31:0] a_v [NREQ];
  logic [31:0] b_v [NREQ];

  f32_mult_arb #(.NREQ(NREQ), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_p(resp_p), .resp_err(resp_err),
    .busy(busy), .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
    .mul_done(mul_done), .mul_p(mul_p)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference IEEE-754 single multiply via double arithmetic (exact for the operands used here).
  function automatic logic [31:0] fmul_ref(input logic [31:0] a, input logic [31:0] b);
    real ra, rb;
    logic [63:0] d;
    logic [10:0] e;
    ra = $bitstoreal({a[31], {3'd0, a[30:23]} + 11'd896, a[22:0], 29'd0});
    rb = $bitstoreal({b[31], {3'd0, b[30:23]} + 11'd896, b[22:0], 29'd0});
    d  = $realtobits(ra * rb);
    e  = d[62:52] - 11'd896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  function automatic logic [31:0] rand_op();
    return {1'($urandom_range(0, 1)), 8'($urandom_range(100, 150)),
            8'($urandom_range(0, 255)), 15'd0};
  endfunction

  // Round robin: first valid requester after the last one served, wrapping around.
  function automatic int rr_pick(input int last, input logic [NREQ-1:0] v);
    for (int k = 1; k <= NREQ; k++) begin
      if (v[(last + k) % NREQ]) return (last + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b);
    a_v[i] = a;
    b_v[i] = b;
    req_a[32*i +: 32] = a;
    req_b[32*i +: 32] = b;
  endtask

  // One full operation starting at an IDLE negedge; mode 0 drop, 1 keep, 2 randomize requests.
  task automatic run_op(input int lat, input bit stale, input int bp, input int mode,
                        input bit tmo, output int got_g, output logic [31:0] got_p);
    int g, nw, j;
    logic [31:0] ea, eb, ep;
    logic eerr;
    #1;
    g = rr_pick(last_g, req_valid);
    got_g = g;
    if (g < 0) begin
      check_val("no_request", 32'd0, 32'd1);
      return;
    end
    check_val("busy_idle", {31'd0, busy}, 32'd0);
    check_val("req_ready", {28'd0, req_ready}, 32'd1 << g);
    ea = a_v[g];
    eb = b_v[g];
    ep = tmo ? 32'h7FC0_0000 : fmul_ref(ea, eb);
    eerr = tmo;
    @(negedge clk);
    check_val("mul_start_issue", {31'd0, mul_start}, 32'd1);
    check_val("mul_a", mul_a, ea);
    check_val("mul_b", mul_b, eb);
    check_val("busy_issue", {31'd0, busy}, 32'd1);
    check_val("ready_issue", {28'd0, req_ready}, 32'd0);
    if (mode == 0) begin
      req_valid[g] = 1'b0;
    end else if (mode == 2) begin
      for (int i = 0; i < NREQ; i++) begin
        if (i == g || !req_valid[i]) begin
          req_valid[i] = 1'($urandom_range(0, 1));
          if (req_valid[i]) set_req(i, rand_op(), rand_op());
        end
      end
      if (req_valid == '0) begin
        j = $urandom_range(0, NREQ - 1);
        req_valid[j] = 1'b1;
        set_req(j, rand_op(), rand_op());
      end
    end
    mul_done = stale;
    mul_p    = $urandom;
    nw = tmo ? TMO : lat;
    for (int k = 1; k <= nw; k++) begin
      @(negedge clk);
      check_val("mul_start_wait", {31'd0, mul_start}, 32'd0);
      check_val("resp_valid_wait", {28'd0, resp_valid}, 32'd0);
      check_val("ready_wait", {28'd0, req_ready}, 32'd0);
      if (!tmo && k == lat) begin
        mul_done = 1'b1;
        mul_p    = ep;
      end else begin
        mul_done = 1'b0;
        mul_p    = $urandom;
      end
    end
    @(negedge clk);
    mul_done = 1'b0;
    got_p = resp_p;
    for (int r = 0; r <= bp; r++) begin
      check_val("resp_valid", {28'd0, resp_valid}, 32'd1 << g);
      check_val("resp_p", resp_p, ep);
      check_val("resp_err", {31'd0, resp_err}, {31'd0, eerr});
      check_val("mul_start_resp", {31'd0, mul_start}, 32'd0);
      check_val("ready_resp", {28'd0, req_ready}, 32'd0);
      mul_p = $urandom;
      if (r == bp) resp_ready = NREQ'($urandom) | (NREQ'(1) << g);
      else         resp_ready = NREQ'($urandom) & ~(NREQ'(1) << g);
      @(negedge clk);
    end
    resp_ready = '0;
    check_val("resp_valid_clr", {28'd0, resp_valid}, 32'd0);
    check_val("busy_after", {31'd0, busy}, 32'd0);
    check_val("mul_start_after", {31'd0, mul_start}, 32'd0);
    last_g = g;
  endtask

  initial begin
    int g;
    logic [31:0] p;
    int ord [5] = '{0, 1, 2, 3, 0};
    logic [31:0] dir_a [4] = '{32'h3FC0_0000, 32'h4040_0000, 32'h4080_0000, 32'h3F80_0000};

    rst_n      = 1'b0;
    req_a      = '0;
    req_b      = '0;
    resp_ready = '0;
    mul_done   = 1'b0;
    mul_p      = 32'h0;
    last_g     = NREQ - 1;
    for (int i = 0; i < NREQ; i++) set_req(i, dir_a[i], 32'h4000_0000);
    req_valid = '1;
    repeat (2) @(negedge clk);
    check_val("rst_ready", {28'd0, req_ready}, 32'd0);
    check_val("rst_busy", {31'd0, busy}, 32'd0);
    check_val("rst_start", {31'd0, mul_start}, 32'd0);
    check_val("rst_resp_valid", {28'd0, resp_valid}, 32'd0);
    check_val("rst_resp_p", resp_p, 32'd0);
    check_val("rst_mul_a", mul_a, 32'd0);
    check_val("rst_mul_b", mul_b, 32'd0);
    rst_n = 1'b1;

    // Contention: all four held valid, service order 0,1,2,3,0.
    for (int k = 0; k < 5; k++) begin
      run_op(2, 1'b0, 0, 1, 1'b0, g, p);
      check_val("rr_order", g, ord[k]);
      if (k == 1) check_val("contention_p1", p, 32'h40C0_0000);
    end

    req_valid = '0;
    #1;
    check_val("idle_ready", {28'd0, req_ready}, 32'd0);
    repeat (3) begin
      @(negedge clk);
      check_val("idle_busy", {31'd0, busy}, 32'd0);
      check_val("idle_start", {31'd0, mul_start}, 32'd0);
    end

    set_req(0, 32'h3FC0_0000, 32'h4000_0000);
    req_valid = 4'b0001;
    run_op(3, 1'b0, 0, 0, 1'b0, g, p);
    check_val("single_g", g, 0);
    check_val("single_p", p, 32'h4040_0000);

    set_req(2, rand_op(), rand_op());
    req_valid = 4'b0100;
    run_op(1, 1'b0, 5, 0, 1'b0, g, p);
    check_val("bp_g", g, 2);

    set_req(1, rand_op(), rand_op());
    req_valid = 4'b0010;
    run_op(1, 1'b1, 0, 0, 1'b0, g, p);
    set_req(1, rand_op(), rand_op());
    req_valid = 4'b0010;
    run_op(3, 1'b1, 1, 0, 1'b0, g, p);

    for (int i = 0; i < NREQ; i++) set_req(i, rand_op(), rand_op());
    req_valid = 4'b0101;
    for (int n = 0; n < 120; n++) begin
      run_op($urandom_range(1, 7), 1'($urandom_range(0, 1)), $urandom_range(0, 3), 2, 1'b0, g, p);
    end

    // Reset during WAIT, then requester 0 must win over 1 and 3.
    for (int i = 0; i < NREQ; i++) set_req(i, rand_op(), rand_op());
    req_valid = 4'b1011;
    @(negedge clk);
    @(negedge clk);
    mul_done = 1'b0;
    rst_n = 1'b0;
    #1;
    check_val("mrst_ready", {28'd0, req_ready}, 32'd0);
    check_val("mrst_busy", {31'd0, busy}, 32'd0);
    check_val("mrst_start", {31'd0, mul_start}, 32'd0);
    check_val("mrst_mul_a", mul_a, 32'd0);
    check_val("mrst_resp_p", resp_p, 32'd0);
    @(negedge clk);
    rst_n  = 1'b1;
    last_g = NREQ - 1;
    run_op(2, 1'b0, 0, 0, 1'b0, g, p);
    check_val("mrst_g", g, 0);

`ifdef MULT_TIMEOUT_EN
    set_req(3, rand_op(), rand_op());
    req_valid = 4'b1000;
    run_op(0, 1'b0, 1, 0, 1'b1, g, p);
    check_val("tmo_p", p, 32'h7FC0_0000);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/f32_mult_arb.md
Name: f32_mult_arb

Overview:
- Round-robin arbiter and sequencer that shares one f32_mult instance between NREQ requesters.
- Accepts operand pairs over per-requester valid/ready, issues a one-cycle start pulse to the multiplier and waits for done.
- Returns the product to the granted requester over a per-requester valid/ready response channel.
- Sits between the FP clients and the single f32_mult datapath; one operation in flight at a time.

Parameters:
- NREQ, 4, number of requesters (>= 2).
- TIMEOUT_CYCLES, 64, cycles in WAIT before abort; used only with MULT_TIMEOUT_EN.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  NREQ  requester i presents operands.
- req_ready  output  NREQ  one-hot; operands of requester i accepted this cycle.
- req_a  input  32*NREQ  operand A, requester i at bits [32*i+31:32*i].
- req_b  input  32*NREQ  operand B, same packing.
- resp_valid  output  NREQ  one-hot; product valid for requester i.
- resp_ready  input  NREQ  requester i accepts the response.
- resp_p  output  32  product (shared bus; qualified by resp_valid).
- resp_err  output  1  timeout flag, qualified by resp_valid.
- busy  output  1  high whenever state != IDLE.
- mul_start  output  1  start pulse to f32_mult.
- mul_a, mul_b  output  32  multiplier operands, held stable from ISSUE until done.
- mul_done  input  1  f32_mult done.
- mul_p  input  32  f32_mult product.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; req_ready=0, resp_valid=0, resp_p=0, resp_err=0, busy=0, mul_start=0, mul_a=mul_b=0; last_grant=NREQ-1, so requester 0 has first priority.
- IDLE: if any req_valid, grant g = first set bit searching upward from last_grant+1 (mod NREQ).
  - Same cycle: req_ready[g]=1 (combinational), latch req_a/req_b slice g into mul_a/mul_b, latch g; go ISSUE.
  - If no req_valid: stay in IDLE.
- ISSUE: mul_start=1 for exactly this cycle; go WAIT. mul_done is ignored in ISSUE (it may be stale from the previous op).
- WAIT: mul_start=0. On the first cycle with mul_done=1, register resp_p=mul_p and resp_err=0; go RESP.
- RESP: resp_valid[g]=1, resp_p held.
  - When resp_ready[g]=1: clear resp_valid, last_grant=g, go IDLE.
  - The earliest next grant is the cycle after the response handshake.
- Requester handshake: req_valid must stay high with stable operands until req_ready. Deasserting earlier simply removes the request from arbitration.
- Latency: request accepted at cycle T, mul_start at T+1. If done arrives at T+1+L, resp_valid is asserted at T+2+L.
- Simultaneous requests: exactly one req_ready per accept. Round robin guarantees each valid requester a grant within NREQ operations.
- req_valid[g] asserted again while g is in RESP: not granted until IDLE. It then competes with g at lowest priority.
- mul_a/mul_b change only in IDLE on grant.
- Grant index width: $clog2(NREQ).

Optional Feature:
- MULT_TIMEOUT_EN defined:
  - A counter clears on entry to WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT_CYCLES without mul_done: go RESP with resp_p=32'h7FC00000 (qNaN) and resp_err=1.
  - A late mul_done arriving in IDLE or ISSUE is ignored.
- MULT_TIMEOUT_EN undefined: WAIT persists until mul_done; no counter logic; resp_err constant 0.

Test Plan:
- Single request: requester 0, a=3FC00000, b=40000000 -> req_ready[0] one cycle; one mul_start pulse; resp_valid[0] with resp_p=40400000, resp_err=0.
- Contention: all four req_valid held high from reset, distinct operands -> grant order 0,1,2,3,0. Each resp_p matches its own operands (e.g. 40400000*40000000=40C00000 for requester 1).
- Response backpressure: resp_ready[2] held low 5 cycles -> resp_valid[2] and resp_p held stable; no new mul_start until 1 cycle after the handshake.
- Stale done: mul_done held high through ISSUE -> ignored. Completion is taken from the first done in WAIT; resp_p equals mul_p sampled then.
- Reset mid-operation: rst_n low during WAIT -> all outputs 0 immediately. After release, requester 0 wins over 1 and 3 when all are valid.
- MULT_TIMEOUT_EN with TIMEOUT_CYCLES=8 and mul_done tied 0 -> resp_valid on the 9th cycle after mul_start, resp_p=7FC00000, resp_err=1.
